// File: rtl/pushbutton_irq_sequencer_if.sv
// Avalon-MM link between the button sequencer (master) and the pushbutton PIO (slave).
interface pushbutton_irq_sequencer_if;
    logic [1:0]  m_address;
    logic        m_chipselect;
    logic        m_write_n;
    logic [31:0] m_writedata;
    logic [31:0] m_readdata;

    modport master (
        output m_address,
        output m_chipselect,
        output m_write_n,
        output m_writedata,
        input  m_readdata
    );

    modport slave (
        input  m_address,
        input  m_chipselect,
        input  m_write_n,
        input  m_writedata,
        output m_readdata
    );
endinterface

// File: rtl/pushbutton_irq_sequencer.sv
// Services the pushbutton PIO without a CPU: programs the irq mask, reads and
// clears edge capture, reports each serviced set of buttons, then debounces.
module pushbutton_irq_sequencer #(
    parameter int                 NUM_BTN        = 4,
    parameter int                 HOLDOFF_CYCLES = 500000,
    parameter int                 HOLDOFF_W      = 20,
    parameter logic [NUM_BTN-1:0] INIT_MASK      = NUM_BTN'(4'hF)
) (
    input  logic                       clk,
    input  logic                       reset_n,
    pushbutton_irq_sequencer_if.master m,
    input  logic                       pio_irq,
    input  logic [NUM_BTN-1:0]         cfg_mask,
    input  logic                       cfg_update,
    output logic                       event_valid,
    output logic [NUM_BTN-1:0]         event_bits,
    output logic [15:0]                event_count,
    output logic                       busy
);
    localparam logic [1:0] ADDR_MASK = 2'd2;
    localparam logic [1:0] ADDR_EDGE = 2'd3;
    localparam logic [HOLDOFF_W-1:0] HOLD_LAST =
        (HOLDOFF_CYCLES > 0) ? HOLDOFF_W'(HOLDOFF_CYCLES - 1) : '0;

    // INIT only exists during reset; INITW is the cycle the init mask write is on the bus.
    typedef enum logic [2:0] {
        S_INIT, S_INITW, S_IDLE, S_MASK,
        S_RD, S_RDW, S_CLR, S_HOLD
    } state_t;

    state_t               state_q, state_d;
    logic [1:0]           addr_q, addr_d;
    logic                 cs_q, cs_d;
    logic                 wn_q, wn_d;
    logic [31:0]          wd_q, wd_d;
    logic                 ev_q, ev_d;
    logic [NUM_BTN-1:0]   bits_q, bits_d;
    logic [15:0]          cnt_q, cnt_d;
    logic                 busy_q, busy_d;
    logic [HOLDOFF_W-1:0] hold_q, hold_d;
    logic [NUM_BTN-1:0]   mask_q, mask_d;
    logic                 pend_q, pend_d;
    logic [NUM_BTN-1:0]   cap;

    assign cap = m.m_readdata[NUM_BTN-1:0];

    generate
        if (NUM_BTN < 32) begin : g_rd_hi
            logic unused_rd_hi;
            assign unused_rd_hi = |m.m_readdata[31:NUM_BTN];
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        addr_d  = '0;
        cs_d    = 1'b0;
        wn_d    = 1'b1;
        wd_d    = '0;
        ev_d    = 1'b0;
        bits_d  = bits_q;
        cnt_d   = cnt_q;
        hold_d  = hold_q;
        mask_d  = mask_q;
        pend_d  = pend_q;
        unique case (state_q)
            S_INIT: begin
                state_d = S_INITW;
                cs_d    = 1'b1;
                wn_d    = 1'b0;
                addr_d  = ADDR_MASK;
                wd_d    = 32'(INIT_MASK);
            end
            S_INITW, S_MASK: state_d = S_IDLE;
            S_IDLE: begin
                if (pend_q) begin
                    state_d = S_MASK;
                    cs_d    = 1'b1;
                    wn_d    = 1'b0;
                    addr_d  = ADDR_MASK;
                    wd_d    = 32'(mask_q);
                    pend_d  = 1'b0;
                end else if (pio_irq) begin
                    state_d = S_RD;
                    cs_d    = 1'b1;
                    addr_d  = ADDR_EDGE;
                end
            end
            S_RD: state_d = S_RDW;
            S_RDW: begin
                // Clear only what was read so later edges keep the irq raised.
                if (cap != '0) begin
                    state_d = S_CLR;
                    cs_d    = 1'b1;
                    wn_d    = 1'b0;
                    addr_d  = ADDR_EDGE;
                    wd_d    = 32'(cap);
                    ev_d    = 1'b1;
                    bits_d  = cap;
                    cnt_d   = cnt_q + 16'd1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CLR: begin
                if (HOLDOFF_CYCLES == 0) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_HOLD;
                    hold_d  = HOLD_LAST;
                end
            end
            S_HOLD: begin
                if (hold_q == '0) state_d = S_IDLE;
                else              hold_d  = hold_q - HOLDOFF_W'(1);
            end
            default: state_d = S_INIT;
        endcase
        if (cfg_update) begin
            mask_d = cfg_mask;
            pend_d = 1'b1;
        end
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= S_INIT;
            addr_q  <= '0;
            cs_q    <= 1'b0;
            wn_q    <= 1'b1;
            wd_q    <= '0;
            ev_q    <= 1'b0;
            bits_q  <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            hold_q  <= '0;
            mask_q  <= INIT_MASK;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cs_q    <= cs_d;
            wn_q    <= wn_d;
            wd_q    <= wd_d;
            ev_q    <= ev_d;
            bits_q  <= bits_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            hold_q  <= hold_d;
            mask_q  <= mask_d;
            pend_q  <= pend_d;
        end
    end

    assign m.m_address   = addr_q;
    assign m.m_chipselect = cs_q;
    assign m.m_write_n   = wn_q;
    assign m.m_writedata = wd_q;
    assign event_valid   = ev_q;
    assign event_bits    = bits_q;
    assign event_count   = cnt_q;
    assign busy          = busy_q;
endmodule

// File: tb/tb_pushbutton_irq_sequencer.sv
// Bench for pushbutton_irq_sequencer: a small PIO model on the bus plus an
// event scoreboard, with one task per scenario.
module tb_pushbutton_irq_sequencer;
    localparam int NB = 4;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          pio_irq;
    logic [NB-1:0] cfg_mask = '0;
    logic          cfg_update = 1'b0;
    logic          event_valid;
    logic [NB-1:0] event_bits;
    logic [15:0]   event_count;
    logic          busy;

    pushbutton_irq_sequencer_if bus ();

    pushbutton_irq_sequencer #(
        .NUM_BTN(NB),
        .HOLDOFF_CYCLES(8),
        .HOLDOFF_W(4),
        .INIT_MASK(4'hF)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .m(bus),
        .pio_irq(pio_irq),
        .cfg_mask(cfg_mask),
        .cfg_update(cfg_update),
        .event_valid(event_valid),
        .event_bits(event_bits),
        .event_count(event_count),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int n_run = 0;
    int n_fail = 0;

    // PIO model: edge capture, irq mask, registered readdata.
    logic [NB-1:0] edge_cap = '0;
    logic [NB-1:0] pio_mask = '0;
    logic [NB-1:0] inject = '0;
    logic          irq_force = 1'b0;
    logic [31:0]   rdata = '0;
    logic          clr_hit;
    logic [NB-1:0] clr_bits;

    assign clr_hit  = bus.m_chipselect && !bus.m_write_n && bus.m_address == 2'd3;
    assign clr_bits = clr_hit ? bus.m_writedata[NB-1:0] : '0;

    always @(posedge clk) begin
        edge_cap <= (edge_cap & ~clr_bits) | inject;
        if (bus.m_chipselect && !bus.m_write_n && bus.m_address == 2'd2)
            pio_mask <= bus.m_writedata[NB-1:0];
        if (bus.m_chipselect && bus.m_write_n)
            rdata <= (bus.m_address == 2'd3) ? 32'(edge_cap) : 32'd0;
    end

    assign bus.m_readdata = rdata;
    assign pio_irq = (|(edge_cap & pio_mask)) | irq_force;

    typedef struct packed {
        logic        wr;
        logic [1:0]  addr;
        logic [31:0] data;
    } acc_t;

    acc_t          acc_q[$];
    logic [NB-1:0] exp_ev[$];
    logic [NB-1:0] sb_e;
    logic [15:0]   exp_cnt = '0;
    int            ev_seen = 0;

    always @(negedge clk) begin
        if (reset_n === 1'b1) begin
            if (bus.m_chipselect === 1'b1)
                acc_q.push_back({!bus.m_write_n, bus.m_address, bus.m_writedata});
            if (event_valid === 1'b1) begin
                ev_seen++;
                n_run++;
                if (exp_ev.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_event: got bits %h, expected no event", event_bits);
                end else begin
                    sb_e = exp_ev.pop_front();
                    if (event_bits !== sb_e) begin
                        n_fail++;
                        $display("FAIL sb_event: got bits %h, expected %h", event_bits, sb_e);
                    end
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_ev(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (event_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_idle(input string nm);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (busy === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
        n_run++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s_idle: busy=%b, expected 0 within 40 cycles", nm, busy);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        tick(3);
        n_run++;
        if ({bus.m_address, bus.m_chipselect, bus.m_write_n, bus.m_writedata}
            !== {2'd0, 1'b0, 1'b1, 32'd0}) begin
            n_fail++;
            $display("FAIL rst_bus: got a=%h cs=%b wn=%b wd=%h, expected 0 0 1 0",
                     bus.m_address, bus.m_chipselect, bus.m_write_n, bus.m_writedata);
        end
        n_run++;
        if ({event_valid, event_bits, event_count, busy} !== {1'b0, 4'h0, 16'h0, 1'b1}) begin
            n_fail++;
            $display("FAIL rst_out: got ev=%b bits=%h cnt=%h busy=%b, expected 0 0 0 1",
                     event_valid, event_bits, event_count, busy);
        end
        reset_n = 1'b1;
        tick(1);
        n_run++;
        if ({bus.m_chipselect, bus.m_write_n, bus.m_address, bus.m_writedata, busy}
            !== {1'b1, 1'b0, 2'd2, 32'h0000000F, 1'b1}) begin
            n_fail++;
            $display("FAIL init_wr: got cs=%b wn=%b a=%h wd=%h busy=%b, expected 1 0 2 0000000f 1",
                     bus.m_chipselect, bus.m_write_n, bus.m_address, bus.m_writedata, busy);
        end
        tick(1);
        n_run++;
        if (busy !== 1'b0 || bus.m_chipselect !== 1'b0) begin
            n_fail++;
            $display("FAIL init_done: got busy=%b cs=%b, expected 0 0", busy, bus.m_chipselect);
        end
        tick(2);
        n_run++;
        if (acc_q.size() != 1) begin
            n_fail++;
            $display("FAIL init_count: got %0d accesses, expected 1", acc_q.size());
        end
        acc_q.delete();
    endtask

    task automatic test_single();
        int busy_n;
        inject = 4'h5;
        exp_ev.push_back(4'h5);
        exp_cnt = exp_cnt + 16'd1;
        tick(1);
        inject = '0;
        n_run++;
        if (pio_irq !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL single_T: got irq=%b busy=%b, expected 1 0", pio_irq, busy);
        end
        tick(1);
        n_run++;
        if ({bus.m_chipselect, bus.m_write_n, bus.m_address} !== {1'b1, 1'b1, 2'd3}) begin
            n_fail++;
            $display("FAIL single_rd: got cs=%b wn=%b a=%h, expected 1 1 3",
                     bus.m_chipselect, bus.m_write_n, bus.m_address);
        end
        tick(1);
        n_run++;
        if (bus.m_chipselect !== 1'b0) begin
            n_fail++;
            $display("FAIL single_rdw: got cs=%b, expected 0", bus.m_chipselect);
        end
        tick(1);
        n_run++;
        if ({bus.m_chipselect, bus.m_write_n, bus.m_address, bus.m_writedata}
            !== {1'b1, 1'b0, 2'd3, 32'h5}) begin
            n_fail++;
            $display("FAIL single_clr: got cs=%b wn=%b a=%h wd=%h, expected 1 0 3 00000005",
                     bus.m_chipselect, bus.m_write_n, bus.m_address, bus.m_writedata);
        end
        n_run++;
        if ({event_valid, event_bits, event_count} !== {1'b1, 4'h5, exp_cnt}) begin
            n_fail++;
            $display("FAIL single_ev: got ev=%b bits=%h cnt=%h, expected 1 5 %h",
                     event_valid, event_bits, event_count, exp_cnt);
        end
        busy_n = 0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (busy !== 1'b1) break;
            busy_n++;
        end
        n_run++;
        if (busy_n != 8) begin
            n_fail++;
            $display("FAIL single_hold: got %0d busy holdoff cycles, expected 8", busy_n);
        end
        n_run++;
        if ({event_valid, event_bits} !== {1'b0, 4'h5}) begin
            n_fail++;
            $display("FAIL single_bits_hold: got ev=%b bits=%h, expected 0 5",
                     event_valid, event_bits);
        end
    endtask

    task automatic test_race();
        bit ok;
        inject = 4'h1;
        exp_ev.push_back(4'h1);
        exp_cnt = exp_cnt + 16'd1;
        tick(1);
        inject = '0;
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (bus.m_chipselect === 1'b1 && bus.m_write_n === 1'b1) begin
                ok = 1'b1;
                break;
            end
            tick(1);
        end
        n_run++;
        if (!ok) begin
            n_fail++;
            $display("FAIL race_rd: got no read, expected read within 10 cycles");
        end
        tick(1);
        inject = 4'h2;
        exp_ev.push_back(4'h2);
        exp_cnt = exp_cnt + 16'd1;
        tick(1);
        inject = '0;
        n_run++;
        if ({bus.m_chipselect, bus.m_write_n, bus.m_address, bus.m_writedata}
            !== {1'b1, 1'b0, 2'd3, 32'h1}) begin
            n_fail++;
            $display("FAIL race_clr: got cs=%b wn=%b a=%h wd=%h, expected 1 0 3 00000001",
                     bus.m_chipselect, bus.m_write_n, bus.m_address, bus.m_writedata);
        end
        wait_ev(40, ok);
        n_run++;
        if (!ok || event_bits !== 4'h2 || event_count !== exp_cnt) begin
            n_fail++;
            $display("FAIL race_second: got ok=%b bits=%h cnt=%h, expected 1 2 %h",
                     ok, event_bits, event_count, exp_cnt);
        end
        wait_idle("race");
    endtask

    task automatic test_spurious();
        int ev0;
        ev0 = ev_seen;
        acc_q.delete();
        irq_force = 1'b1;
        tick(1);
        irq_force = 1'b0;
        tick(6);
        n_run++;
        if (acc_q.size() != 1) begin
            n_fail++;
            $display("FAIL spur_acc: got %0d accesses, expected 1 read", acc_q.size());
        end else if (acc_q[0].wr !== 1'b0 || acc_q[0].addr !== 2'd3) begin
            n_fail++;
            $display("FAIL spur_acc: got wr=%b a=%h, expected read of 3",
                     acc_q[0].wr, acc_q[0].addr);
        end
        n_run++;
        if (ev_seen != ev0 || event_count !== exp_cnt || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL spur_ev: got events=%0d cnt=%h busy=%b, expected %0d %h 0",
                     ev_seen - ev0, event_count, busy, 0, exp_cnt);
        end
    endtask

    task automatic test_cfg_hold();
        bit ok;
        inject = 4'h4;
        exp_ev.push_back(4'h4);
        exp_cnt = exp_cnt + 16'd1;
        tick(1);
        inject = '0;
        wait_ev(30, ok);
        tick(1);
        acc_q.delete();
        inject = 4'h1;
        exp_ev.push_back(4'h1);
        exp_cnt = exp_cnt + 16'd1;
        tick(1);
        inject = '0;
        cfg_mask = 4'h3;
        cfg_update = 1'b1;
        tick(1);
        cfg_update = 1'b0;
        wait_ev(40, ok);
        tick(2);
        n_run++;
        if (!ok || acc_q.size() < 3) begin
            n_fail++;
            $display("FAIL cfg_seq: got ok=%b %0d accesses, expected 1 and 3", ok, acc_q.size());
        end else begin
            n_run++;
            if (acc_q[0] !== {1'b1, 2'd2, 32'h3}) begin
                n_fail++;
                $display("FAIL cfg_mask_wr: got %h, expected %h", acc_q[0], {1'b1, 2'd2, 32'h3});
            end
            n_run++;
            if (acc_q[1].wr !== 1'b0 || acc_q[1].addr !== 2'd3) begin
                n_fail++;
                $display("FAIL cfg_rd: got wr=%b a=%h, expected 0 3", acc_q[1].wr, acc_q[1].addr);
            end
            n_run++;
            if (acc_q[2] !== {1'b1, 2'd3, 32'h1}) begin
                n_fail++;
                $display("FAIL cfg_clr: got %h, expected %h", acc_q[2], {1'b1, 2'd3, 32'h1});
            end
        end
        wait_idle("cfg");
    endtask

    task automatic test_cfg_last_wins();
        bit ok;
        inject = 4'h2;
        exp_ev.push_back(4'h2);
        exp_cnt = exp_cnt + 16'd1;
        tick(1);
        inject = '0;
        wait_ev(30, ok);
        tick(1);
        acc_q.delete();
        cfg_mask = 4'h3;
        cfg_update = 1'b1;
        tick(1);
        cfg_mask = 4'h6;
        tick(1);
        cfg_update = 1'b0;
        wait_idle("lw");
        tick(4);
        n_run++;
        if (acc_q.size() != 1 || acc_q[0] !== {1'b1, 2'd2, 32'h6}) begin
            n_fail++;
            $display("FAIL last_wins: got %0d accesses first=%h, expected 1 %h",
                     acc_q.size(), acc_q.size() > 0 ? acc_q[0] : '0, {1'b1, 2'd2, 32'h6});
        end
        n_run++;
        if (pio_mask !== 4'h6) begin
            n_fail++;
            $display("FAIL last_wins_mask: got %h, expected 6", pio_mask);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        inject = 4'h4;
        exp_ev.push_back(4'h4);
        exp_cnt = exp_cnt + 16'd1;
        tick(1);
        inject = '0;
        wait_ev(30, ok);
        tick(1);
        inject = 4'h2;
        exp_ev.push_back(4'h2);
        tick(1);
        inject = '0;
        reset_n = 1'b0;
        tick(1);
        n_run++;
        if ({bus.m_address, bus.m_chipselect, bus.m_write_n, bus.m_writedata}
            !== {2'd0, 1'b0, 1'b1, 32'd0}) begin
            n_fail++;
            $display("FAIL mid_rst_bus: got a=%h cs=%b wn=%b wd=%h, expected 0 0 1 0",
                     bus.m_address, bus.m_chipselect, bus.m_write_n, bus.m_writedata);
        end
        n_run++;
        if ({event_valid, event_bits, event_count, busy} !== {1'b0, 4'h0, 16'h0, 1'b1}) begin
            n_fail++;
            $display("FAIL mid_rst_out: got ev=%b bits=%h cnt=%h busy=%b, expected 0 0 0 1",
                     event_valid, event_bits, event_count, busy);
        end
        exp_cnt = 16'd1;
        tick(1);
        acc_q.delete();
        reset_n = 1'b1;
        wait_ev(40, ok);
        tick(1);
        n_run++;
        if (!ok || event_bits !== 4'h2 || event_count !== exp_cnt) begin
            n_fail++;
            $display("FAIL mid_service: got ok=%b bits=%h cnt=%h, expected 1 2 %h",
                     ok, event_bits, event_count, exp_cnt);
        end
        n_run++;
        if (acc_q.size() < 3 || acc_q[0] !== {1'b1, 2'd2, 32'hF}
            || acc_q[1].wr !== 1'b0 || acc_q[2] !== {1'b1, 2'd3, 32'h2}) begin
            n_fail++;
            $display("FAIL mid_seq: got %0d accesses first=%h, expected init write %h then read, clear 2",
                     acc_q.size(), acc_q.size() > 0 ? acc_q[0] : '0, {1'b1, 2'd2, 32'hF});
        end
        wait_idle("mid");
    endtask

    task test_wrap();
        bit ok;
        force dut.cnt_q = 16'hFFFF;
        tick(1);
        release dut.cnt_q;
        tick(1);
        n_run++;
        if (event_count !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL wrap_pre: got %h, expected ffff", event_count);
        end
        inject = 4'h8;
        exp_ev.push_back(4'h8);
        tick(1);
        inject = '0;
        wait_ev(30, ok);
        exp_cnt = 16'h0000;
        n_run++;
        if (!ok || event_count !== exp_cnt) begin
            n_fail++;
            $display("FAIL wrap: got ok=%b cnt=%h, expected 1 %h", ok, event_count, exp_cnt);
        end
        wait_idle("wrap");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single();
        test_race();
        test_spurious();
        test_cfg_hold();
        test_cfg_last_wins();
        test_reset_mid();
        test_wrap();
        n_run++;
        if (exp_ev.size() != 0) begin
            n_fail++;
            $display("FAIL sb_leftover: got %0d unserved events, expected 0", exp_ev.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
